// File: rtl/outbox_uart_tx.sv
// OUTBOX drain: pops one FIFO word at a time and sends it on an 8N1 UART line.
// Optional HEX_ASCII_EN sends each byte as two hex digits plus CR LF.
module outbox_uart_tx #(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       out_empty,
    input  logic [7:0] out_data,
    output logic       out_rd,
    output logic       tx,
    output logic       busy
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] RELOAD = BW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;

`ifdef HEX_ASCII_EN
    logic [1:0] chr_q, chr_d;
    logic [7:0] data_q, data_d;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        logic [7:0] r;
        if (n < 4'd10) r = 8'h30 + {4'h0, n};
        else           r = 8'h37 + {4'h0, n};
        return r;
    endfunction

    function automatic logic [7:0] char_sel(input logic [7:0] b,
                                            input logic [1:0] idx);
        logic [7:0] r;
        unique case (idx)
            2'd0: r = hex_char(b[7:4]);
            2'd1: r = hex_char(b[3:0]);
            2'd2: r = 8'h0D;
            2'd3: r = 8'h0A;
        endcase
        return r;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        out_rd  = 1'b0;
`ifdef HEX_ASCII_EN
        chr_d   = chr_q;
        data_d  = data_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!out_empty) state_d = S_POP;
            end
            S_POP: begin
                // FWFT: head word is already valid, capture it on the pop edge
                if (!out_empty) begin
                    out_rd  = 1'b1;
                    state_d = S_START;
                    baud_d  = RELOAD;
                    bit_d   = 3'd0;
`ifdef HEX_ASCII_EN
                    data_d  = out_data;
                    chr_d   = 2'd0;
                    sh_d    = char_sel(out_data, 2'd0);
`else
                    sh_d    = out_data;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_q == '0) begin
                    state_d = S_DATA;
                    baud_d  = RELOAD;
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            S_DATA: begin
                if (baud_q == '0) begin
                    baud_d = RELOAD;
                    sh_d   = {1'b0, sh_q[7:1]};
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            S_STOP: begin
                if (baud_q == '0) begin
`ifdef HEX_ASCII_EN
                    if (chr_q != 2'd3) begin
                        chr_d   = chr_q + 2'd1;
                        sh_d    = char_sel(data_q, chr_q + 2'd1);
                        state_d = S_START;
                        baud_d  = RELOAD;
                    end else if (!out_empty) begin
                        state_d = S_POP;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    if (!out_empty) state_d = S_POP;
                    else            state_d = S_IDLE;
`endif
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // line level follows the next state so tx is a clean flop output
        tx_d = 1'b1;
        if (state_d == S_START)     tx_d = 1'b0;
        else if (state_d == S_DATA) tx_d = sh_d[0];
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            sh_q    <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

`ifdef HEX_ASCII_EN
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            chr_q  <= 2'd0;
            data_q <= 8'h00;
        end else begin
            chr_q  <= chr_d;
            data_q <= data_d;
        end
    end
`endif

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_outbox_uart_tx.sv
// Bench for outbox_uart_tx: FIFO model plus a frame-level reference
// computed from byte values and bit-slot arithmetic.
module tb_outbox_uart_tx;

    localparam int CLK_HZ = 40;
    localparam int BAUD   = 10;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int FBITS  = 10 * DIV;
`ifdef HEX_ASCII_EN
    localparam int NFR = 4;
`else
    localparam int NFR = 1;
`endif
    localparam int FLEN = NFR * FBITS;

    logic       clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       out_empty;
    logic [7:0] out_data;
    logic       out_rd;
    logic       tx;
    logic       busy;

    logic [7:0] fifo[$];
    logic [7:0] expq[$];
    int total = 0;
    int bad = 0;

    outbox_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .i_rst     (i_rst),
        .out_empty (out_empty),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        out_empty = (fifo.size() == 0);
        out_data  = out_empty ? 8'h00 : fifo[0];
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        expq.push_back(b);
        refresh();
    endtask

    // advance one cycle: from a negedge to the next negedge
    task automatic step();
        logic popped;
        popped = out_rd;
        @(posedge clk);
        #1;
        if (popped && fifo.size() > 0) void'(fifo.pop_front());
        refresh();
        @(negedge clk);
    endtask

    function automatic logic [7:0] model_char(input logic [7:0] b,
                                              input int f);
`ifdef HEX_ASCII_EN
        string s;
        s = $sformatf("%02X", b);
        if (f == 0) return s[0];
        if (f == 1) return s[1];
        if (f == 2) return 8'h0D;
        return 8'h0A;
`else
        if (f < 0) return 8'h00;
        return b;
`endif
    endfunction

    function automatic logic exp_tx(input logic [7:0] b, input int k);
        int f;
        int slot;
        logic [7:0] c;
        f    = (k - 1) / FBITS;
        slot = ((k - 1) % FBITS) / DIV;
        c    = model_char(b, f);
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return c[slot-1];
    endfunction

    // called at the negedge of the POP cycle; checks offsets 1..upto
    task automatic frame(input string tag, input logic [7:0] b,
                         input int upto);
        chk({tag, "_pop_busy"}, busy, 1);
        for (int k = 1; k <= upto; k++) begin
            step();
            chk($sformatf("%s_tx@%0d", tag, k), tx, exp_tx(b, k));
            chk($sformatf("%s_busy@%0d", tag, k), busy, 1);
            chk($sformatf("%s_rd@%0d", tag, k), out_rd, 0);
        end
    endtask

    task automatic wait_pop(input string tag, input int lat);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (out_rd !== 1'b1 && n < 200);
        chk({tag, "_poplat"}, n, lat);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_idle_tx"}, tx, 1);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_rd"}, out_rd, 0);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] hold;
        int n;
        out_empty = 1'b1;
        out_data  = 8'h00;

        // reset held with data waiting: no pop, line idle
        push(8'($urandom));
        repeat (20) begin
            step();
            idle_chk("rsthold");
        end
        i_rst = 1'b1;
        step();
        chk("rel_pop", out_rd, 1);
        frame("first", expq.pop_front(), FLEN);
        step();
        idle_chk("first_end");

        // single 0xA5
        push(8'hA5);
        wait_pop("a5", 1);
        frame("a5", expq.pop_front(), FLEN);
        step();
        idle_chk("a5_end");

        // back-to-back 0x00, 0xFF
        push(8'h00);
        push(8'hFF);
        wait_pop("b2b", 1);
        frame("b00", expq.pop_front(), FLEN);
        step();
        chk("b2b_second_pop", out_rd, 1);
        chk("b2b_gap_tx", tx, 1);
        frame("bff", expq.pop_front(), FLEN);
        step();
        idle_chk("b2b_end");

        // 0x3C (four contiguous frames in hex mode)
        push(8'h3C);
        wait_pop("x3c", 1);
        frame("x3c", expq.pop_front(), FLEN);
        step();
        idle_chk("x3c_end");

        // random bursts with random idle gaps
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) push(8'($urandom));
            wait_pop($sformatf("rnd%0d", r), 1);
            for (int j = 0; j < n; j++) begin
                frame($sformatf("rnd%0d_%0d", r, j), expq.pop_front(), FLEN);
                step();
                if (j < n - 1) chk($sformatf("rnd%0d_b2b", r), out_rd, 1);
                else           idle_chk($sformatf("rnd%0d_end", r));
            end
            repeat ($urandom_range(0, 5)) begin
                step();
                idle_chk("gap");
            end
        end

        // reset during data bit 3 of 0x5A; next word must follow cleanly
        b = 8'($urandom);
        push(8'h5A);
        push(b);
        wait_pop("abort", 1);
        hold = expq.pop_front();
        frame("abort", hold, 1 + DIV * 4 + 1);
        #1 i_rst = 1'b0;
        #1;
        idle_chk("abort_rst");
        step();
        idle_chk("abort_rst2");
        i_rst = 1'b1;
        step();
        chk("abort_next_pop", out_rd, 1);
        frame("after_abort", expq.pop_front(), FLEN);
        step();
        idle_chk("after_abort_end");

        // long empty stretch
        repeat (1000) begin
            step();
            idle_chk("empty");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
